// File: rtl/hls_cnn_2d_100s_pkg.sv
// Shared widths, FSM state type and the rescale/round/saturate helper for the
// 2D conv accumulator and the pooling stage.
package hls_cnn_2d_100s_pkg;

    localparam int PROD_WIDTH = 27;
    localparam int ACC_WIDTH  = 32;
    localparam int OUT_WIDTH  = 16;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } conv_state_e;

    // Round half up at ACC_WIDTH+1 bits so the rounding constant cannot overflow.
    function automatic logic signed [OUT_WIDTH-1:0] sat_round(
        input logic signed [ACC_WIDTH-1:0] sum,
        input int                          shift,
        input bit                          relu
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] r;
        logic signed [ACC_WIDTH:0] omax;
        logic signed [ACC_WIDTH:0] omin;
        logic signed [OUT_WIDTH-1:0] res;
        omax = ((ACC_WIDTH+1)'(1) <<< (OUT_WIDTH-1)) - (ACC_WIDTH+1)'(1);
        omin = -((ACC_WIDTH+1)'(1) <<< (OUT_WIDTH-1));
        ext  = {sum[ACC_WIDTH-1], sum};
        r    = (ext + ((ACC_WIDTH+1)'(1) <<< (shift-1))) >>> shift;
        if (r > omax)      res = omax[OUT_WIDTH-1:0];
        else if (r < omin) res = omin[OUT_WIDTH-1:0];
        else               res = r[OUT_WIDTH-1:0];
        if (relu && res[OUT_WIDTH-1]) res = '0;
        return res;
    endfunction

endpackage

// File: rtl/hls_cnn_2d_100s_round_sat.sv
// Combinational rescale path: round-half-up shift, saturate to the activation
// range, optional ReLU.
module hls_cnn_2d_100s_round_sat #(
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 10,
    parameter bit RELU       = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0] sum_i,
    output logic signed [OUT_WIDTH-1:0] res_o
);
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] OMAX = (EW'(1) <<< (OUT_WIDTH-1)) - EW'(1);
    localparam logic signed [EW-1:0] OMIN = -(EW'(1) <<< (OUT_WIDTH-1));
    localparam logic signed [EW-1:0] RND  = EW'(1) <<< (FRAC_SHIFT-1);

    logic signed [EW-1:0]        ext;
    logic signed [EW-1:0]        rnd;
    logic signed [EW-1:0]        shd;
    logic signed [OUT_WIDTH-1:0] sat;

    always_comb begin
        ext = {sum_i[ACC_WIDTH-1], sum_i};
        rnd = ext + RND;
        shd = rnd >>> FRAC_SHIFT;
        if (shd > OMAX)      sat = OMAX[OUT_WIDTH-1:0];
        else if (shd < OMIN) sat = OMIN[OUT_WIDTH-1:0];
        else                 sat = shd[OUT_WIDTH-1:0];
        res_o = (RELU && sat[OUT_WIDTH-1]) ? '0 : sat;
    end

endmodule

// File: rtl/hls_cnn_2d_100s_conv_acc.sv
// Per-pixel conv accumulator: bias + NUM_TERMS products, rescaled to a 16-bit
// activation and handed downstream over valid/ready.
module hls_cnn_2d_100s_conv_acc
    import hls_cnn_2d_100s_pkg::*;
#(
    parameter int PROD_WIDTH = hls_cnn_2d_100s_pkg::PROD_WIDTH,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = hls_cnn_2d_100s_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = hls_cnn_2d_100s_pkg::OUT_WIDTH,
    parameter int NUM_TERMS  = 9,
    parameter int FRAC_SHIFT = 10,
    parameter bit RELU       = 1'b1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_valid,
    input  logic                         prod_last,
    output logic                         prod_ready,
    input  logic signed [BIAS_WIDTH-1:0] bias_data,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_len,
    output logic                         busy
);
    localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

    conv_state_e                 state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;
    logic                        err_q, err_d;

    logic                        accept;
    logic                        at_last;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] rs_res;

    // Gating with reset keeps the upstream from seeing ready while held in reset.
    assign prod_ready = ap_rst_n & (state_q == S_ACC);
    assign out_valid  = (state_q == S_OUT);
    assign out_data   = out_q;
    assign err_len    = err_q;
    assign busy       = (cnt_q != '0) | (state_q == S_OUT);

    assign accept  = prod_valid & prod_ready;
    assign at_last = (cnt_q == CW'(NUM_TERMS-1));
    assign base    = (cnt_q == '0) ? (ACC_WIDTH'(bias_data) <<< FRAC_SHIFT) : acc_q;
    assign sum     = base + ACC_WIDTH'(prod_data);

    hls_cnn_2d_100s_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU       (RELU)
    ) u_round_sat (
        .sum_i (sum),
        .res_o (rs_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    // prod_last only flags mismatches; the counter owns framing.
                    if (prod_last != at_last) err_d = 1'b1;
                    if (at_last) begin
                        out_d   = rs_res;
                        state_d = S_OUT;
                        cnt_d   = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_ACC;
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

endmodule
